// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for the load response,
// aligns load data, and supplies bypass information to earlier stages.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_to_mem_valid,
    output logic        MEM_allow_in,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_rf_we,
    input  logic        ex_res_from_mem,
    input  logic [31:0] ex_alu_result,
    input  logic [2:0]  ex_ld_op,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mem_to_wb_valid,
    input  logic        WB_allow_in,
    output logic        MEM_ready_go,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rf_waddr,
    output logic        wb_rf_we,
    output logic        wb_res_from_mem,
    output logic [31:0] wb_data,
    output logic [31:0] wb_alu_result,
    output logic        fwd_we,
    output logic [4:0]  fwd_waddr,
    output logic [31:0] fwd_data,
    output logic        fwd_load_pending,
    input  logic        mem_flush
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, alu_q, alu_d, data_q, data_d;
    logic [RW-1:0]     waddr_q, waddr_d;
    logic              we_q, we_d, ld_q, ld_d;
    logic [2:0]        op_q, op_d;
    logic              enter, latch, capture;
    logic [XLEN-1:0]   byte_sh, half_sh, aligned;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Hold register for the resident instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= '0;
            alu_q   <= '0;
            data_q  <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            op_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            op_q    <= op_d;
        end
    end

    assign enter = ex_to_mem_valid & MEM_allow_in;

    // Next state; a flush overrides entry and response capture
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        if (mem_flush) begin
            valid_d = 1'b0;
            // Response still outstanding: drain it before accepting new work
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !data_sram_data_ok)
                state_d = S_DRAIN;
            else
                state_d = S_IDLE;
        end else begin
            case (state_q)
                S_WAIT:  if (data_sram_data_ok) state_d = S_READY;
                S_DRAIN: if (data_sram_data_ok) state_d = S_IDLE;
                default: begin
                    if (enter) begin
                        valid_d = 1'b1;
                        state_d = ex_res_from_mem ? S_WAIT : S_READY;
                    end else if (MEM_ready_go && WB_allow_in) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs derived from the current state
    always_comb begin
        MEM_ready_go     = valid_q && (state_q == S_READY);
        mem_to_wb_valid  = MEM_ready_go;
        MEM_allow_in     = (state_q != S_DRAIN) && (!valid_q || (MEM_ready_go && WB_allow_in));
        fwd_load_pending = valid_q && ld_q && (state_q != S_READY);
        fwd_we           = valid_q && we_q;
    end

    // Load data alignment by latched address offset
    always_comb begin
        byte_sh = data_sram_rdata >> {alu_q[1:0], 3'b000};
        half_sh = data_sram_rdata >> {alu_q[1], 4'b0000};
        case (op_q)
            3'd1:    aligned = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'd2:    aligned = {24'd0, byte_sh[7:0]};
            3'd3:    aligned = {{16{half_sh[15]}}, half_sh[15:0]};
            3'd4:    aligned = {16'd0, half_sh[15:0]};
            default: aligned = data_sram_rdata;
        endcase
    end

    assign latch   = enter && !mem_flush;
    assign capture = (state_q == S_WAIT) && data_sram_data_ok && !mem_flush;

    always_comb begin
        pc_d    = pc_q;
        alu_d   = alu_q;
        data_d  = data_q;
        waddr_d = waddr_q;
        we_d    = we_q;
        ld_d    = ld_q;
        op_d    = op_q;
        if (latch) begin
            pc_d    = ex_pc;
            alu_d   = ex_alu_result;
            data_d  = '0;
            waddr_d = ex_rf_waddr;
            we_d    = ex_rf_we;
            ld_d    = ex_res_from_mem;
            op_d    = ex_ld_op;
        end else if (capture) begin
            data_d  = aligned;
        end
    end

    assign wb_pc           = pc_q;
    assign wb_rf_waddr     = waddr_q;
    assign wb_rf_we        = we_q;
    assign wb_res_from_mem = ld_q;
    assign wb_data         = data_q;
    assign wb_alu_result   = alu_q;
    assign fwd_waddr       = waddr_q;
    assign fwd_data        = ld_q ? data_q : alu_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions compared against an arithmetic model of load alignment.
module tb_mem_stage;
    logic        clk, resetn;
    logic        ex_to_mem_valid, MEM_allow_in;
    logic [31:0] ex_pc, ex_alu_result;
    logic [4:0]  ex_rf_waddr;
    logic        ex_rf_we, ex_res_from_mem;
    logic [2:0]  ex_ld_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_to_wb_valid, WB_allow_in, MEM_ready_go;
    logic [31:0] wb_pc, wb_data, wb_alu_result, fwd_data;
    logic [4:0]  wb_rf_waddr, fwd_waddr;
    logic        wb_rf_we, wb_res_from_mem, fwd_we, fwd_load_pending, mem_flush;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk(clk), .resetn(resetn),
        .ex_to_mem_valid(ex_to_mem_valid), .MEM_allow_in(MEM_allow_in),
        .ex_pc(ex_pc), .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we),
        .ex_res_from_mem(ex_res_from_mem), .ex_alu_result(ex_alu_result), .ex_ld_op(ex_ld_op),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_valid(mem_to_wb_valid), .WB_allow_in(WB_allow_in), .MEM_ready_go(MEM_ready_go),
        .wb_pc(wb_pc), .wb_rf_waddr(wb_rf_waddr), .wb_rf_we(wb_rf_we),
        .wb_res_from_mem(wb_res_from_mem), .wb_data(wb_data), .wb_alu_result(wb_alu_result),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
        .fwd_load_pending(fwd_load_pending), .mem_flush(mem_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected load value from the ISA rules, using plain arithmetic
    function automatic logic [31:0] ref_align(input int op, input int off, input logic [31:0] rd);
        longint unsigned w;
        longint s;
        w = 64'(rd);
        case (op)
            1, 2: begin
                s = longint'((w / (64'd1 << (8 * off))) % 256);
                if (op == 1 && s >= 128) s = s - 256;
            end
            3, 4: begin
                s = longint'((w / (64'd1 << (16 * (off / 2)))) % 65536);
                if (op == 3 && s >= 32768) s = s - 65536;
            end
            default: s = longint'(w);
        endcase
        return 32'(s);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] wa, input logic we,
                        input logic ld, input logic [2:0] op, input logic [31:0] alu);
        ex_pc = pc; ex_rf_waddr = wa; ex_rf_we = we;
        ex_res_from_mem = ld; ex_ld_op = op; ex_alu_result = alu;
        ex_to_mem_valid = 1'b1;
        #1;
        checks++;
        if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL send_allow_in: got %b want 1", MEM_allow_in); end
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
    endtask

    task automatic do_alu(input string nm, input logic [31:0] pc, input logic [4:0] wa,
                          input logic we, input logic [31:0] alu);
        WB_allow_in = 1'b1;
        send(pc, wa, we, 1'b0, 3'd0, alu);
        checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", nm, mem_to_wb_valid); end
        checks++; if (fwd_data !== alu) begin errors++; $display("FAIL %s_fwd_data: got %h want %h", nm, fwd_data, alu); end
        checks++; if (wb_pc !== pc) begin errors++; $display("FAIL %s_wb_pc: got %h want %h", nm, wb_pc, pc); end
        checks++; if ({fwd_we, fwd_waddr} !== {we, wa}) begin errors++; $display("FAIL %s_fwd_we_waddr: got %b/%0d want %b/%0d", nm, fwd_we, fwd_waddr, we, wa); end
        checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL %s_allow_in: got %b want 1", nm, MEM_allow_in); end
        cyc();
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got %b want 0", nm, mem_to_wb_valid); end
    endtask

    // Load with `delay` idle WAIT cycles before data_ok, then `stall` cycles of WB backpressure
    task automatic do_load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rd, input int delay, input int stall);
        logic [31:0] exp;
        exp = ref_align(int'(op), int'(addr[1:0]), rd);
        WB_allow_in = 1'b1;
        send(addr ^ 32'h4000_0000, 5'd9, 1'b1, 1'b1, op, addr);
        for (int i = 0; i < delay; i++) begin
            data_sram_rdata = $urandom;
            #1;
            checks++; if (fwd_load_pending !== 1'b1) begin errors++; $display("FAIL %s_pending: got %b want 1", nm, fwd_load_pending); end
            cyc();
        end
        data_sram_rdata = rd; data_sram_data_ok = 1'b1;
        #1;
        checks++; if (fwd_load_pending !== 1'b1 || mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL %s_last_wait: got pend=%b valid=%b want 1/0", nm, fwd_load_pending, mem_to_wb_valid); end
        WB_allow_in = (stall == 0);
        cyc();
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < stall; i++) begin
            data_sram_rdata = $urandom; data_sram_data_ok = 1'($urandom_range(0, 1));
            #1;
            checks++; if (wb_data !== exp || mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL %s_stall_hold: got %h/%b want %h/1", nm, wb_data, mem_to_wb_valid, exp); end
            checks++; if (MEM_allow_in !== 1'b0) begin errors++; $display("FAIL %s_stall_allow: got %b want 0", nm, MEM_allow_in); end
            cyc();
        end
        data_sram_data_ok = 1'b0;
        WB_allow_in = 1'b1;
        #1;
        checks++; if (mem_to_wb_valid !== 1'b1 || fwd_load_pending !== 1'b0) begin errors++; $display("FAIL %s_ready: got valid=%b pend=%b want 1/0", nm, mem_to_wb_valid, fwd_load_pending); end
        checks++; if (wb_data !== exp) begin errors++; $display("FAIL %s_wb_data: got %h want %h", nm, wb_data, exp); end
        checks++; if (fwd_data !== exp) begin errors++; $display("FAIL %s_fwd_data: got %h want %h", nm, fwd_data, exp); end
        checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL %s_allow_out: got %b want 1", nm, MEM_allow_in); end
        cyc();
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL %s_leave: got %b want 0", nm, mem_to_wb_valid); end
    endtask

    task automatic test_reset();
        checks++; if ({mem_to_wb_valid, fwd_we, fwd_load_pending} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {mem_to_wb_valid, fwd_we, fwd_load_pending}); end
        checks++; if ({wb_pc, wb_data, wb_alu_result, fwd_data} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {wb_pc, wb_data, wb_alu_result, fwd_data}); end
        checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow: got %b want 1", MEM_allow_in); end
    endtask

    task automatic test_nonload();
        do_alu("nonload", 32'h0000_1000, 5'd5, 1'b1, 32'h0000_1234);
    endtask

    task automatic test_load_byte();
        do_load("ld_b", 3'd1, 32'h0000_2003, 32'h80FF_0000, 2, 0);
        do_load("ld_bu", 3'd2, 32'h0000_2003, 32'h80FF_0000, 2, 0);
    endtask

    task automatic test_load_half_word();
        do_load("ld_h", 3'd3, 32'h0000_3002, 32'h8001_7FFF, 1, 0);
        do_load("ld_hu", 3'd4, 32'h0000_3002, 32'h8001_7FFF, 1, 0);
        do_load("ld_w", 3'd0, 32'h0000_3000, 32'h8001_7FFF, 1, 0);
        do_load("ld_h_odd", 3'd3, 32'h0000_3003, 32'h8001_7FFF, 0, 0);
    endtask

    task automatic test_stall();
        do_load("stall", 3'd0, 32'h0000_4000, 32'hCAFE_F00D, 1, 4);
    endtask

    task automatic test_flush();
        WB_allow_in = 1'b1;
        send(32'h5000, 5'd3, 1'b1, 1'b1, 3'd0, 32'h5000);
        cyc();
        mem_flush = 1'b1;
        cyc();
        mem_flush = 1'b0;
        #1;
        checks++; if ({mem_to_wb_valid, fwd_we, fwd_load_pending} !== 3'b000) begin errors++; $display("FAIL flush_valid: got %b want 000", {mem_to_wb_valid, fwd_we, fwd_load_pending}); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (MEM_allow_in !== 1'b0) begin errors++; $display("FAIL flush_drain_allow: got %b want 0", MEM_allow_in); end
            cyc();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        cyc();
        data_sram_data_ok = 1'b0;
        #1;
        checks++; if (MEM_allow_in !== 1'b1 || mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got allow=%b valid=%b want 1/0", MEM_allow_in, mem_to_wb_valid); end
        // Flush together with the response returns straight to idle
        send(32'h5100, 5'd3, 1'b1, 1'b1, 3'd0, 32'h5100);
        mem_flush = 1'b1; data_sram_data_ok = 1'b1;
        cyc();
        mem_flush = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        checks++; if (MEM_allow_in !== 1'b1 || mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_with_ok: got allow=%b valid=%b want 1/0", MEM_allow_in, mem_to_wb_valid); end
        // Flush wins over a simultaneous entry
        ex_to_mem_valid = 1'b1; ex_res_from_mem = 1'b0; mem_flush = 1'b1;
        cyc();
        ex_to_mem_valid = 1'b0; mem_flush = 1'b0;
        #1;
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_vs_entry: got %b want 0", mem_to_wb_valid); end
    endtask

    task automatic test_reset_wait();
        WB_allow_in = 1'b1;
        send(32'h6000, 5'd7, 1'b1, 1'b1, 3'd0, 32'h6004);
        checks++; if (fwd_load_pending !== 1'b1) begin errors++; $display("FAIL rst_pre_pending: got %b want 1", fwd_load_pending); end
        resetn = 1'b0;
        #1;
        checks++; if ({mem_to_wb_valid, fwd_we, fwd_load_pending, MEM_ready_go} !== 4'b0000) begin errors++; $display("FAIL rst_wait_ctrl: got %b want 0000", {mem_to_wb_valid, fwd_we, fwd_load_pending, MEM_ready_go}); end
        checks++; if ({wb_pc, wb_alu_result, fwd_data, 27'(fwd_waddr)} !== 123'd0) begin errors++; $display("FAIL rst_wait_data: got %h/%h want 0", wb_pc, wb_alu_result); end
        #1;
        resetn = 1'b1;
        cyc();
        do_alu("post_reset", 32'h6100, 5'd8, 1'b1, 32'hABCD_0001);
    endtask

    task automatic test_back_to_back();
        WB_allow_in = 1'b1;
        ex_res_from_mem = 1'b0; ex_rf_we = 1'b1; ex_rf_waddr = 5'd2;
        for (int i = 0; i < 5; i++) begin
            ex_pc = 32'h7000 + 32'(i * 4); ex_alu_result = 32'(i * 17 + 1);
            ex_to_mem_valid = 1'b1;
            cyc();
            checks++; if (mem_to_wb_valid !== 1'b1 || wb_pc !== 32'h7000 + 32'(i * 4)) begin errors++; $display("FAIL b2b_%0d: got valid=%b pc=%h want 1/%h", i, mem_to_wb_valid, wb_pc, 32'h7000 + 32'(i * 4)); end
            checks++; if (MEM_allow_in !== 1'b1) begin errors++; $display("FAIL b2b_allow_%0d: got %b want 1", i, MEM_allow_in); end
        end
        ex_to_mem_valid = 1'b0;
        cyc();
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", mem_to_wb_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0)
                do_alu("rnd_alu", $urandom, 5'($urandom), 1'($urandom), $urandom);
            else
                do_load("rnd_ld", 3'($urandom_range(0, 7)), $urandom, $urandom,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        resetn = 1'b0; ex_to_mem_valid = 1'b0; ex_pc = '0; ex_rf_waddr = '0; ex_rf_we = 1'b0;
        ex_res_from_mem = 1'b0; ex_alu_result = '0; ex_ld_op = '0; data_sram_data_ok = 1'b0;
        data_sram_rdata = '0; WB_allow_in = 1'b1; mem_flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        #1;
        test_reset();
        test_nonload();
        test_load_byte();
        test_load_half_word();
        test_stall();
        test_flush();
        test_reset_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 clock; resetn in 1 reset.
- One clock, clk.
- Reset is asynchronous and active-low, resetn.
REQ-002 SHALL have EX-side ports:
- ex_to_mem_valid in 1: EX presents an instruction.
- MEM_allow_in out 1: stage can accept.
- ex_pc in 32; ex_rf_waddr in 5; ex_rf_we in 1.
- ex_res_from_mem in 1: instruction is a load whose request EX already issued.
- ex_alu_result in 32: result or load address.
- ex_ld_op in 3: 0 W, 1 B, 2 BU, 3 H, 4 HU, others treated as W.
REQ-003 SHALL have memory-side ports: data_sram_data_ok in 1; data_sram_rdata in 32.
REQ-004 SHALL have WB-side ports:
- mem_to_wb_valid out 1; WB_allow_in in 1; MEM_ready_go out 1.
- wb_pc out 32; wb_rf_waddr out 5; wb_rf_we out 1; wb_res_from_mem out 1.
- wb_data out 32: aligned load data; wb_alu_result out 32.
REQ-005 SHALL have bypass and control ports:
- fwd_we out 1; fwd_waddr out 5; fwd_data out 32.
- fwd_load_pending out 1: EX/ID must stall.
- mem_flush in 1: cancel the held instruction.

Function
REQ-006 SHALL hold one instruction in a register with internal valid bit; the state machine has states IDLE, WAIT, READY, DRAIN.
REQ-007 SHALL drive MEM_allow_in = (state!=DRAIN) & (!valid | (MEM_ready_go & WB_allow_in)).
REQ-008 SHALL latch all ex_* fields on the cycle ex_to_mem_valid & MEM_allow_in.
- Next state is WAIT if ex_res_from_mem, else READY.
- With no new entry and the instruction leaving (MEM_ready_go & WB_allow_in), next state is IDLE and valid clears.
REQ-009 SHALL sample data_sram_data_ok only in WAIT or DRAIN.
- data_ok in WAIT captures the aligned data into the hold register and moves to READY.
- A data_ok in any other state is ignored.
REQ-010 SHALL drive MEM_ready_go = valid & (state==READY); mem_to_wb_valid = MEM_ready_go.
REQ-011 SHALL hold captured load data stable in READY while WB_allow_in=0, for any number of cycles.
REQ-012 SHALL compute alignment with off = ex_alu_result[1:0] latched:
- B/BU: byte at bits [8*off+7 : 8*off], sign-extended for B, zero-extended for BU.
- H/HU: halfword at bits [16*off[1]+15 : 16*off[1]], sign- or zero-extended.
- W: whole word.
- off[0] is ignored for H/HU.
REQ-013 SHALL drive fwd_we = valid & wb_rf_we and fwd_waddr = wb_rf_waddr.
- fwd_data = wb_res_from_mem ? wb_data : wb_alu_result.
- fwd_load_pending = valid & wb_res_from_mem & (state!=READY).
REQ-014 SHALL handle mem_flush by clearing valid the next cycle:
- Flush in WAIT moves to DRAIN; otherwise moves to IDLE.
- In DRAIN, the next data_ok is discarded and the state moves to IDLE.
- MEM_allow_in stays 0 throughout DRAIN.
REQ-015 SHALL give mem_flush priority when it coincides with EX entry or data_ok.
- Flush in WAIT with data_ok in the same cycle moves to IDLE, since the response is consumed.
REQ-016 SHALL make a non-load entry visible to WB one cycle after latch: latency 1 with no wait.
- For a load, mem_to_wb_valid asserts the cycle after data_ok.
REQ-017 SHALL allow back-to-back flow: a departure and a new entry in the same cycle keep valid=1.

Reset
REQ-018 SHALL on resetn=0 asynchronously set state=IDLE and valid=0, and zero all wb_* and fwd_* outputs.
REQ-019 SHALL, on reset during WAIT or DRAIN, drop the outstanding response.
- The memory interface is reset by the same resetn.

Verification
REQ-020 Non-load: alu_result=0x1234, waddr=5, we=1, WB_allow_in=1 -> next cycle mem_to_wb_valid=1, fwd_data=0x1234, MEM_allow_in=1.
REQ-021 LD_B, addr=...03, rdata=0x80FF_0000, data_ok 3 cycles after entry:
- fwd_load_pending=1 for 3 cycles.
- Then wb_data=0xFFFF_FF80.
- LD_BU with the same stimulus -> wb_data=0x0000_0080.
REQ-022 LD_H, off=2, rdata=0x8001_7FFF -> wb_data=0xFFFF_8001; LD_HU -> 0x0000_8001; LD_W -> 0x8001_7FFF.
REQ-023 WB_allow_in=0 for 4 cycles after data_ok:
- wb_data stays stable and MEM_allow_in=0.
- Later rdata changes are ignored.
REQ-024 mem_flush in WAIT:
- valid=0 next cycle and MEM_allow_in=0 until data_ok.
- The response is discarded with no mem_to_wb_valid.
- A flush concurrent with data_ok goes straight to IDLE.
REQ-025 resetn asserted mid-WAIT -> outputs zero immediately; after release, first entry is accepted normally.
